partial_sat_eval: RTL and testbench
===================================

// Module: partial_sat_eval
// PURPOSE
// - Decides whether one clause is already satisfied by the current partial assignment.
// - Satisfied means at least one active literal is assigned and evaluates true.
// - Sits beside the sub-clause evaluation path of the SAT engine.
// - Feeds the clause-status logic that skips satisfied clauses during BCP.
// - Registered, single-cycle pipeline with valid qualification.
// PARAMETERS
// - VAR_PER_CLAUSE  default `VAR_PER_CLAUSE (5)  number of literal slots per clause
// PORTS
// - Interface: one clock; reset is synchronous and active-high.
// - clock        in   1               system clock, rising edge
// - reset        in   1               synchronous, active-high
// - in_valid     in   1               input vectors are valid this cycle
// - unassign     in   VAR_PER_CLAUSE  1 = variable in slot i is unassigned
// - clause_mask  in   VAR_PER_CLAUSE  1 = slot i holds a real literal; 0 = unused slot
// - val          in   VAR_PER_CLAUSE  assigned value of variable in slot i
// - clause_pole  in   VAR_PER_CLAUSE  literal polarity of slot i; lit_true = val ^ clause_pole
// - out_valid    out  1               registered copy of in_valid
// - partial_sat  out  1               clause has >=1 assigned true active literal
// - sat_lits     out  VAR_PER_CLAUSE  per-slot true-literal vector
// BEHAVIOUR
// - Per slot: sat_lits_c[i] = clause_mask[i] & ~unassign[i] & (val[i] ^ clause_pole[i]).
// - partial_sat_c = |sat_lits_c.
// - Don't-care inputs:
//   - unassigned or masked slots never contribute;
//   - their val and clause_pole values are ignored.
// - Latency 1 cycle: at a rising edge with in_valid=1, sat_lits <= sat_lits_c and partial_sat <= partial_sat_c.
// - out_valid <= in_valid every cycle.
// - in_valid=0: sat_lits and partial_sat hold their previous values; out_valid goes 0 next cycle.
// - Reset (synchronous, priority over in_valid): out_valid=0, partial_sat=0, sat_lits=0.
// - Reset mid-stream discards the in-flight result.
// - Empty clause (clause_mask=0) -> partial_sat=0.
//   - Clause emptiness is the conflict logic's job, not this block's.
// - All slots unassigned -> partial_sat=0, regardless of mask.
// - No handshake back-pressure; a new input is accepted every cycle.
// TESTING
// - Reset: reset=1 with any inputs -> next edge out_valid=0, partial_sat=0, sat_lits=0.
// - One true literal: unassign=01111, mask=11100, val=00000, pole=11100 -> partial_sat=1, sat_lits=10000.
// - Two true literals: unassign=01000, mask=11100, val=01000, pole=10100 -> partial_sat=1, sat_lits=10100.
// - All assigned false: unassign=00100, mask=11111, val=00011, pole=00111 -> partial_sat=0, sat_lits=00000.
// - None assigned: unassign=11111, mask=11111, val=00000, pole=11100 -> partial_sat=0.
// - Empty clause: unassign=00000, mask=00000, random val/pole -> partial_sat=0.
//   - Also: in_valid=0 holds the previous output, and back-to-back inputs give one result per cycle.

Source files
------------

// File: rtl/partial_sat_eval.sv
// Flags a clause already satisfied by the current partial assignment: at least one
// active, assigned slot whose literal evaluates true. One registered stage, valid-qualified.
module partial_sat_eval #(
    parameter int unsigned VAR_PER_CLAUSE = 5
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_in_valid,
    input  logic [VAR_PER_CLAUSE-1:0] i_unassign,
    input  logic [VAR_PER_CLAUSE-1:0] i_clause_mask,
    input  logic [VAR_PER_CLAUSE-1:0] i_val,
    input  logic [VAR_PER_CLAUSE-1:0] i_clause_pole,
    output logic                      o_out_valid,
    output logic                      o_partial_sat,
    output logic [VAR_PER_CLAUSE-1:0] o_sat_lits
);

    logic [VAR_PER_CLAUSE-1:0] w_sat_lits;
    logic                      w_partial_sat;

    logic                      r_out_valid;
    logic                      r_partial_sat;
    logic [VAR_PER_CLAUSE-1:0] r_sat_lits;

    // Masked or unassigned slots are forced low, so their val/pole never matter.
    always_comb begin
        w_sat_lits    = i_clause_mask & ~i_unassign & (i_val ^ i_clause_pole);
        w_partial_sat = |w_sat_lits;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_valid   <= 1'b0;
            r_partial_sat <= 1'b0;
            r_sat_lits    <= '0;
        end else begin
            r_out_valid <= i_in_valid;
            if (i_in_valid) begin
                r_partial_sat <= w_partial_sat;
                r_sat_lits    <= w_sat_lits;
            end
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_partial_sat = r_partial_sat;
    assign o_sat_lits    = r_sat_lits;

endmodule

// File: tb/tb_partial_sat_eval.sv
// Scoreboard bench for partial_sat_eval: a driver queues hand-computed results,
// a monitor checks every cycle's outputs against them.
module tb_partial_sat_eval;

    localparam int unsigned N = 5;

    typedef struct packed {
        logic         sat;
        logic [N-1:0] lits;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [N-1:0] unassign;
    logic [N-1:0] clause_mask;
    logic [N-1:0] val;
    logic [N-1:0] clause_pole;
    logic         out_valid;
    logic         partial_sat;
    logic [N-1:0] sat_lits;

    exp_t exp_q[$];
    exp_t last_exp = '0;
    int   n_pass   = 0;
    int   n_total  = 0;

    partial_sat_eval #(.VAR_PER_CLAUSE(N)) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_in_valid   (in_valid),
        .i_unassign   (unassign),
        .i_clause_mask(clause_mask),
        .i_val        (val),
        .i_clause_pole(clause_pole),
        .o_out_valid  (out_valid),
        .o_partial_sat(partial_sat),
        .o_sat_lits   (sat_lits)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Inputs change on the falling edge; a valid, non-reset input queues its result.
    task automatic drive(input logic rst, input logic v, input logic [N-1:0] ua,
                         input logic [N-1:0] m, input logic [N-1:0] va,
                         input logic [N-1:0] po, input logic exp_sat,
                         input logic [N-1:0] exp_lits);
        @(negedge clock);
        reset       = rst;
        in_valid    = v;
        unassign    = ua;
        clause_mask = m;
        val         = va;
        clause_pole = po;
        if (v && !rst) exp_q.push_back('{sat: exp_sat, lits: exp_lits});
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin : monitor
        logic rst_s;
        logic iv_s;
        exp_t e;
        forever begin
            @(posedge clock);
            rst_s = reset;
            iv_s  = in_valid;
            #1;
            if (rst_s) begin
                last_exp = '0;
                check("reset_out_valid", 32'(out_valid), 32'(1'b0));
                check("reset_partial_sat", 32'(partial_sat), 32'(1'b0));
                check("reset_sat_lits", 32'(sat_lits), 32'(0));
            end else begin
                check("out_valid", 32'(out_valid), 32'(iv_s));
                if (out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'(1), 32'(0));
                    end else begin
                        e        = exp_q.pop_front();
                        last_exp = e;
                        check("partial_sat", 32'(partial_sat), 32'(e.sat));
                        check("sat_lits", 32'(sat_lits), 32'(e.lits));
                    end
                end else begin
                    check("hold_partial_sat", 32'(partial_sat), 32'(last_exp.sat));
                    check("hold_sat_lits", 32'(sat_lits), 32'(last_exp.lits));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b1;
        unassign = '0; clause_mask = '1; val = '1; clause_pole = '0;
        // Reset with live inputs that would otherwise be satisfied.
        drive(1, 1, 5'b00000, 5'b11111, 5'b11111, 5'b00000, 0, 5'b00000);
        drive(1, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000);

        // Back-to-back directed vectors.
        drive(0, 1, 5'b01111, 5'b11100, 5'b00000, 5'b11100, 1, 5'b10000);
        drive(0, 1, 5'b01000, 5'b11100, 5'b01000, 5'b10100, 1, 5'b10100);
        drive(0, 1, 5'b00100, 5'b11111, 5'b00011, 5'b00111, 0, 5'b00000);
        drive(0, 1, 5'b11111, 5'b11111, 5'b00000, 5'b11100, 0, 5'b00000);
        drive(0, 1, 5'b00000, 5'b00000, 5'($urandom), 5'($urandom), 0, 5'b00000);
        drive(0, 1, 5'b00000, 5'b00000, 5'($urandom), 5'($urandom), 0, 5'b00000);
        drive(0, 1, 5'b00000, 5'b11111, 5'b10101, 5'b01010, 1, 5'b11111);
        drive(0, 1, 5'b00000, 5'b00001, 5'b00010, 5'b00000, 0, 5'b00000);
        drive(0, 1, 5'b11111, 5'b00000, 5'b11111, 5'b00000, 0, 5'b00000);
        drive(0, 1, 5'b11110, 5'b00001, 5'b00000, 5'b00001, 1, 5'b00001);

        // Idle: outputs must hold the last result (00001) with out_valid low.
        drive(0, 0, 5'b00000, 5'b11111, 5'b11111, 5'b00000, 0, 5'b00000);
        drive(0, 0, 5'b00000, 5'b11111, 5'b11111, 5'b00000, 0, 5'b00000);

        // Valid result, then reset arriving with another valid input that must be dropped.
        drive(0, 1, 5'b00000, 5'b00110, 5'b00100, 5'b00000, 1, 5'b00100);
        drive(1, 1, 5'b00000, 5'b11111, 5'b11111, 5'b00000, 0, 5'b00000);
        drive(0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000);
        drive(0, 1, 5'b00011, 5'b11011, 5'b01000, 5'b00010, 1, 5'b01000);
        drive(0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000);
        drive(0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000);

        @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
